ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arithmetic/link results, plus an
// iterative radix-2 restoring divider that stalls the pipeline and writes HI/LO.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] link_address_i,
    input  logic        is_in_delayslot_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_LUI_OP  = 8'b01011100;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SLLV_OP = 8'b00000100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRLV_OP = 8'b00000110;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_SRAV_OP = 8'b00000111;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

    localparam logic [4:0] NOP_REG_ADDR  = 5'b00000;
    localparam logic       WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] quot_q, rem_q, divisor_q;
    logic        neg_quot_q, neg_rem_q;

    // Delay-slot status only matters to later stages.
    logic unused_ok;
    assign unused_ok = is_in_delayslot_i;

    logic        is_div, is_signed_div;
    logic [31:0] op1_abs, op2_abs, quot_fix, rem_fix;
    logic [32:0] trial;
    logic [4:0]  shamt;
    logic [31:0] alu_res;

    assign is_div        = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign is_signed_div = (aluop_i == EXE_DIV_OP);
    assign op1_abs = (is_signed_div && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign op2_abs = (is_signed_div && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    // Shift in the next dividend bit and try to subtract; bit 32 set means it did not fit.
    assign trial    = {rem_q, quot_q[31]} - {1'b0, divisor_q};
    assign quot_fix = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
    assign rem_fix  = neg_rem_q  ? (~rem_q + 32'd1)  : rem_q;
    assign shamt    = reg1_i[4:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE:   if (is_div) state_d = (reg2_i == '0) ? DIV_BYZERO : DIV_ON;
            DIV_BYZERO: state_d = DIV_END;
            DIV_ON:     if (cnt_q == 6'd31) state_d = DIV_END;
            DIV_END:    state_d = DIV_FREE;
            default:    state_d = DIV_FREE;
        endcase
        if (flush_i) state_d = DIV_FREE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DIV_FREE: begin
                    if (is_div && !flush_i) begin
                        cnt_q      <= '0;
                        rem_q      <= '0;
                        quot_q     <= op1_abs;
                        divisor_q  <= op2_abs;
                        neg_quot_q <= is_signed_div && (reg1_i[31] ^ reg2_i[31]);
                        neg_rem_q  <= is_signed_div && reg1_i[31];
                    end
                end
                DIV_BYZERO: begin
                    quot_q     <= '0;
                    rem_q      <= '0;
                    neg_quot_q <= 1'b0;
                    neg_rem_q  <= 1'b0;
                end
                DIV_ON: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (!trial[32]) begin
                        rem_q  <= trial[31:0];
                        quot_q <= {quot_q[30:0], 1'b1};
                    end else begin
                        rem_q  <= {rem_q[30:0], quot_q[31]};
                        quot_q <= {quot_q[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        alu_res = '0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_AND_OP:             alu_res = reg1_i & reg2_i;
                    EXE_OR_OP, EXE_LUI_OP:  alu_res = reg1_i | reg2_i;
                    EXE_XOR_OP:             alu_res = reg1_i ^ reg2_i;
                    EXE_NOR_OP:             alu_res = ~(reg1_i | reg2_i);
                    default:                alu_res = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP, EXE_SLLV_OP: alu_res = reg2_i << shamt;
                    EXE_SRL_OP, EXE_SRLV_OP: alu_res = reg2_i >> shamt;
                    EXE_SRA_OP, EXE_SRAV_OP: alu_res = $signed(reg2_i) >>> shamt;
                    default:                 alu_res = '0;
                endcase
            end
            EXE_RES_ARITHMETIC: begin
                case (aluop_i)
                    EXE_ADDU_OP: alu_res = reg1_i + reg2_i;
                    EXE_SUBU_OP: alu_res = reg1_i - reg2_i;
                    EXE_SLT_OP:  alu_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
                    EXE_SLTU_OP: alu_res = {31'b0, reg1_i < reg2_i};
                    default:     alu_res = '0;
                endcase
            end
            EXE_RES_JUMP_BRANCH: alu_res = link_address_i;
            default:             alu_res = '0;
        endcase
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = alu_res;
        hi_o       = '0;
        lo_o       = '0;
        whilo_o    = 1'b0;
        stallreq_o = is_div && (state_q != DIV_END) && !flush_i;
        if (state_q == DIV_END && !flush_i) begin
            hi_o    = rem_fix;
            lo_o    = quot_fix;
            whilo_o = 1'b1;
        end
        if (rst) begin
            wd_o       = NOP_REG_ADDR;
            wreg_o     = WRITE_DISABLE;
            wdata_o    = '0;
            hi_o       = '0;
            lo_o       = '0;
            whilo_o    = 1'b0;
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors with literal expectations,
// plus a cycle-level reference model compared on every falling edge.
module tb_ex_stage;

    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_LUI  = 8'b01011100;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_SLT  = 8'b00101010;
    localparam logic [7:0] OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;
    localparam logic [7:0] OP_JAL  = 8'b01010000;
    localparam logic [7:0] OP_NOP  = 8'b00000000;

    localparam logic [2:0] RES_NOP   = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;
    localparam logic [2:0] RES_SHIFT = 3'b010;
    localparam logic [2:0] RES_ARITH = 3'b100;
    localparam logic [2:0] RES_JUMP  = 3'b110;

    logic        clk, rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, link_address_i;
    logic [4:0]  wd_i;
    logic        wreg_i, is_in_delayslot_i, flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .link_address_i(link_address_i), .is_in_delayslot_i(is_in_delayslot_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stallreq_o(stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Reference result of a single-cycle instruction, from the instruction set rules.
    function automatic logic [31:0] alu_ref(input logic [2:0] sel, input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] link);
        logic [63:0] ext;
        ext = {{32{b[31]}}, b};
        if (sel == RES_LOGIC) begin
            if (op == OP_AND) return a & b;
            if (op == OP_OR || op == OP_LUI) return a | b;
            if (op == OP_XOR) return a ^ b;
            if (op == OP_NOR) return ~(a | b);
        end else if (sel == RES_SHIFT) begin
            if (op == OP_SLL) return b << a[4:0];
            if (op == OP_SRL) return b >> a[4:0];
            if (op == OP_SRA) begin
                ext = ext >> a[4:0];
                return ext[31:0];
            end
        end else if (sel == RES_ARITH) begin
            if (op == OP_ADDU) return 32'(a + b);
            if (op == OP_SUBU) return 32'(a - b);
            if (op == OP_SLT)  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            if (op == OP_SLTU) return (a < b) ? 32'd1 : 32'd0;
        end else if (sel == RES_JUMP) begin
            return link;
        end
        return 32'd0;
    endfunction

    // {hi, lo} of a divide; a zero divisor yields zeros.
    function automatic logic [63:0] div_ref(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (op == OP_DIVU) return {a % b, a / b};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // Cycle model: a divide accepted while idle finishes 'lat' cycles later.
    logic        m_busy = 1'b0;
    int          m_age, m_lat;
    logic [31:0] m_hi, m_lo;

    always @(posedge clk) begin
        if (rst || flush_i) begin
            m_busy <= 1'b0;
        end else if (m_busy && m_age == m_lat) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_age <= m_age + 1;
        end else if (is_div_op(aluop_i)) begin
            m_busy <= 1'b1;
            m_age  <= 1;
            m_lat  <= (reg2_i == 0) ? 2 : 33;
            {m_hi, m_lo} <= div_ref(aluop_i, reg1_i, reg2_i);
        end
    end

    always @(negedge clk) begin
        logic exp_done, exp_stall;
        if (rst) begin
            check("rst_wd", 32'(wd_o), 32'd0);
            check("rst_wreg", 32'(wreg_o), 32'd0);
            check("rst_wdata", wdata_o, 32'd0);
            check("rst_hilo", hi_o | lo_o, 32'd0);
            check("rst_whilo", 32'(whilo_o), 32'd0);
            check("rst_stall", 32'(stallreq_o), 32'd0);
        end else begin
            exp_done  = m_busy && (m_age == m_lat) && !flush_i;
            exp_stall = is_div_op(aluop_i) && !flush_i && !(m_busy && m_age == m_lat);
            check("cmp_wd", 32'(wd_o), 32'(wd_i));
            check("cmp_wreg", 32'(wreg_o), 32'(wreg_i));
            check("cmp_wdata", wdata_o,
                  alu_ref(alusel_i, aluop_i, reg1_i, reg2_i, link_address_i));
            check("cmp_stall", 32'(stallreq_o), 32'(exp_stall));
            check("cmp_whilo", 32'(whilo_o), 32'(exp_done));
            check("cmp_hi", hi_o, exp_done ? m_hi : 32'd0);
            check("cmp_lo", lo_o, exp_done ? m_lo : 32'd0);
        end
    end

    task automatic run_vec(input string name, input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] link, input logic [31:0] exp,
                           input logic [4:0] wd, input logic wreg);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
        link_address_i = link; wd_i = wd; wreg_i = wreg;
        #1;
        check({name, "_wdata"}, wdata_o, exp);
        check({name, "_wd"}, 32'(wd_o), 32'(wd));
        check({name, "_wreg"}, 32'(wreg_o), 32'(wreg));
        @(posedge clk); #1;
    endtask

    // Issue a divide at the current cycle and hold it until the result cycle.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi,
                           output int stalls);
        logic done;
        aluop_i = op; alusel_i = RES_NOP; reg1_i = a; reg2_i = b; wreg_i = 1'b0;
        stalls = 0; lo = '0; hi = '0; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (whilo_o) begin
                lo = lo_o; hi = hi_o; done = 1'b1;
                break;
            end
            if (stallreq_o) stalls++;
            @(posedge clk); #1;
        end
        check("div_done", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        aluop_i = OP_NOP; alusel_i = RES_NOP;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lo, hi;
        int stalls, pulses;
        rst = 1'b1; flush_i = 1'b0; is_in_delayslot_i = 1'b0;
        aluop_i = OP_OR; alusel_i = RES_LOGIC; reg1_i = 32'h1; reg2_i = 32'h2;
        wd_i = 5'd5; wreg_i = 1'b1; link_address_i = 32'h0;
        @(posedge clk); #1;
        check("reset_wd", 32'(wd_o), 32'd0);
        check("reset_wdata", wdata_o, 32'd0);
        aluop_i = OP_DIV;
        #1 check("reset_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_vec("or",   OP_OR,   RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 0, 32'h00FFF0F0, 5'd5, 1'b1);
        run_vec("and",  OP_AND,  RES_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 5'd1, 1'b1);
        run_vec("xor",  OP_XOR,  RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 0, 32'hF0F00F0F, 5'd2, 1'b0);
        run_vec("nor",  OP_NOR,  RES_LOGIC, 32'h0000FFFF, 32'h00FF00FF, 0, 32'hFF000000, 5'd3, 1'b1);
        run_vec("lui",  OP_LUI,  RES_LOGIC, 32'h0,        32'h12340000, 0, 32'h12340000, 5'd4, 1'b1);
        run_vec("sll",  OP_SLL,  RES_SHIFT, 32'd4,        32'h0000000F, 0, 32'h000000F0, 5'd6, 1'b1);
        run_vec("srl",  OP_SRL,  RES_SHIFT, 32'd8,        32'h80000000, 0, 32'h00800000, 5'd7, 1'b1);
        run_vec("sra",  OP_SRA,  RES_SHIFT, 32'd4,        32'h80000000, 0, 32'hF8000000, 5'd8, 1'b1);
        run_vec("sra5", OP_SRA,  RES_SHIFT, 32'h24,       32'h7FFFFFF0, 0, 32'h07FFFFFF, 5'd9, 1'b1);
        run_vec("slt",  OP_SLT,  RES_ARITH, 32'hFFFFFFFF, 32'h1,        0, 32'h1,        5'd10, 1'b1);
        run_vec("sltu", OP_SLTU, RES_ARITH, 32'hFFFFFFFF, 32'h1,        0, 32'h0,        5'd11, 1'b1);
        run_vec("addu", OP_ADDU, RES_ARITH, 32'hFFFFFFFF, 32'h2,        0, 32'h1,        5'd12, 1'b1);
        run_vec("subu", OP_SUBU, RES_ARITH, 32'h0,        32'h1,        0, 32'hFFFFFFFF, 5'd13, 1'b1);
        run_vec("jal",  OP_JAL,  RES_JUMP,  32'h0,        32'h0, 32'h00400008, 32'h00400008, 5'd31, 1'b1);
        run_vec("nop",  OP_OR,   RES_NOP,   32'hFFFF,     32'hFFFF,     0, 32'h0,        5'd14, 1'b1);
        run_vec("unk",  8'hFF,   RES_LOGIC, 32'hFFFF,     32'hFFFF,     0, 32'h0,        5'd15, 1'b1);

        run_div(OP_DIVU, 32'd100, 32'd7, lo, hi, stalls);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        check("divu_stalls", 32'(stalls), 32'd33);

        run_div(OP_DIV, 32'hFFFFFFF9, 32'd2, lo, hi, stalls);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        run_div(OP_DIV, 32'd7, 32'd0, lo, hi, stalls);
        check("div0_lo", lo, 32'd0);
        check("div0_hi", hi, 32'd0);
        check("div0_stalls", 32'(stalls), 32'd2);

        run_div(OP_DIVU, 32'd50, 32'd5, lo, hi, stalls);
        check("b2b_first_lo", lo, 32'd10);
        check("b2b_first_hi", hi, 32'd0);
        run_div(OP_DIV, 32'd20, 32'hFFFFFFFA, lo, hi, stalls);
        check("b2b_second_lo", lo, 32'hFFFFFFFD);
        check("b2b_second_hi", hi, 32'd2);

        run_div(OP_DIV, 32'h80000000, 32'd3, lo, hi, stalls);
        check("div_min_lo", lo, 32'hD5555556);
        check("div_min_hi", hi, 32'hFFFFFFFE);
        idle();
        @(posedge clk); #1;

        // Flush during iteration 10 of a signed divide.
        aluop_i = OP_DIV; alusel_i = RES_NOP; reg1_i = 32'd1000; reg2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        #1 check("flush_stall_same", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        idle();
        #1 check("flush_stall_next", 32'(stallreq_o), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (whilo_o) pulses++;
        end
        check("flush_no_whilo", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        run_div(OP_DIVU, 32'd9, 32'd3, lo, hi, stalls);
        check("after_flush_lo", lo, 32'd3);
        check("after_flush_hi", hi, 32'd0);

        // Reset in the middle of a divide abandons it.
        aluop_i = OP_DIVU; alusel_i = RES_NOP; reg1_i = 32'd100; reg2_i = 32'd7;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("midrst_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (whilo_o) pulses++;
        end
        check("midrst_no_whilo", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        run_div(OP_DIVU, 32'hFFFFFFFF, 32'h10, lo, hi, stalls);
        check("post_rst_lo", lo, 32'h0FFFFFFF);
        check("post_rst_hi", hi, 32'h0000000F);
        idle();
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
